// File: rtl/addsub_serial_ctrl_if.sv
// Request/response bundle for addsub_serial_ctrl.
//   Request side : in_valid, in_ready, op_a, op_b, subtract
//   Response side: out_valid, out_ready, result, carry_out, overflow
// slave  = the sequencer's view (drives in_ready and the response fields)
// master = the requester/consumer view (drives the request and out_ready)
interface addsub_serial_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             subtract;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport slave (
        input  in_valid, op_a, op_b, subtract, out_ready,
        output in_ready, out_valid, result, carry_out, overflow
    );

    modport master (
        output in_valid, op_a, op_b, subtract, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow
    );
endinterface

// File: rtl/addsub_serial_ctrl.sv
// Serial WIDTH-bit adder/subtractor built around one 4-bit ripple slice.
// One nibble is processed per clock, least-significant first; the carry
// between nibbles lives in a register. Trades latency (WIDTH/4 cycles) for
// a much smaller adder than a full-width one.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - addsub_serial_ctrl_if.slave: valid/ready request in
//            (op_a, op_b, subtract), valid/ready result out
//            (result, carry_out, overflow).

// Single-bit full adder; four of these form the shared nibble slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub_serial_ctrl_if.slave  bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                      state_q, state_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic                        carry_q, carry_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NIBBLES-1:0][3:0]     a_q, a_d;
    logic [NIBBLES-1:0][3:0]     b_q, b_d;
    logic                        sub_q, sub_d;
    logic [NIBBLES-1:0][3:0]     result_q, result_d;
    logic                        carry_out_q, carry_out_d;
    logic                        overflow_q, overflow_d;

    // Shared nibble slice. B is inverted for subtract; the +1 of the two's
    // complement comes from carry_q being seeded with 'subtract' at accept.
    logic [3:0] a_nib, b_nib, s_nib;
    logic [4:0] c_chain;

    assign a_nib      = a_q[idx_q];
    assign b_nib      = b_q[idx_q] ^ {4{sub_q}};
    assign c_chain[0] = carry_q;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder u_fa (
            .a  (a_nib[i]),
            .b  (b_nib[i]),
            .ci (c_chain[i]),
            .s  (s_nib[i]),
            .co (c_chain[i+1])
        );
    end

    logic last_nib;
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                // in_ready is registered, so it rises one edge after reset
                // release and only an already-visible ready can handshake.
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.op_a;
                    b_d        = bus.op_b;
                    sub_d      = bus.subtract;
                    carry_d    = bus.subtract;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                result_d[idx_q] = s_nib;
                carry_d         = c_chain[4];
                idx_d           = idx_q + IDX_W'(1);
                if (last_nib) begin
                    carry_out_d = c_chain[4];
                    // On the top nibble a_nib[3]/b_nib[3]/s_nib[3] are the
                    // operand and result sign bits.
                    overflow_d  = (a_nib[3] == b_nib[3]) && (s_nib[3] != a_nib[3]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
endmodule
